// File: rtl/mc10_kbd_pkg.sv
// Shared types, scancode constants and the PS/2-set-2 to MC-10 matrix table
// used by the keyboard matrix block and its decoder.
package mc10_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } kbd_state_t;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  localparam logic [7:0] SC_F12    = 8'h07;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Matrix positions as {col[2:0], row[2:0]}
  localparam logic [5:0] POS_A     = {3'd1, 3'd0};
  localparam logic [5:0] POS_ENTER = {3'd6, 3'd3};
  localparam logic [5:0] POS_SHIFT = {3'd7, 3'd6};

  function automatic logic [6:0] hit_pos(input logic [2:0] col, input logic [2:0] row);
    return {1'b1, col, row};
  endfunction

  // Returns {hit, col[2:0], row[2:0]}; E0 12 / E0 59 are deliberately absent.
  function automatic logic [6:0] lookup(input logic ext, input logic [7:0] code);
    logic [6:0] res;
    res = 7'h00;
    case ({ext, code})
      9'h00E: res = hit_pos(3'd0, 3'd0);
      9'h01C: res = {1'b1, POS_A};
      9'h032: res = hit_pos(3'd2, 3'd0);
      9'h021: res = hit_pos(3'd3, 3'd0);
      9'h023: res = hit_pos(3'd4, 3'd0);
      9'h024: res = hit_pos(3'd5, 3'd0);
      9'h02B: res = hit_pos(3'd6, 3'd0);
      9'h034: res = hit_pos(3'd7, 3'd0);
      9'h033: res = hit_pos(3'd0, 3'd1);
      9'h043: res = hit_pos(3'd1, 3'd1);
      9'h03B: res = hit_pos(3'd2, 3'd1);
      9'h042: res = hit_pos(3'd3, 3'd1);
      9'h04B: res = hit_pos(3'd4, 3'd1);
      9'h03A: res = hit_pos(3'd5, 3'd1);
      9'h031: res = hit_pos(3'd6, 3'd1);
      9'h044: res = hit_pos(3'd7, 3'd1);
      9'h04D: res = hit_pos(3'd0, 3'd2);
      9'h015: res = hit_pos(3'd1, 3'd2);
      9'h02D: res = hit_pos(3'd2, 3'd2);
      9'h01B: res = hit_pos(3'd3, 3'd2);
      9'h02C: res = hit_pos(3'd4, 3'd2);
      9'h03C: res = hit_pos(3'd5, 3'd2);
      9'h02A: res = hit_pos(3'd6, 3'd2);
      9'h01D: res = hit_pos(3'd7, 3'd2);
      9'h022: res = hit_pos(3'd0, 3'd3);
      9'h035: res = hit_pos(3'd1, 3'd3);
      9'h01A: res = hit_pos(3'd2, 3'd3);
      9'h05A: res = {1'b1, POS_ENTER};
      9'h15A: res = {1'b1, POS_ENTER};
      9'h029: res = hit_pos(3'd7, 3'd3);
      9'h045: res = hit_pos(3'd0, 3'd4);
      9'h016: res = hit_pos(3'd1, 3'd4);
      9'h01E: res = hit_pos(3'd2, 3'd4);
      9'h026: res = hit_pos(3'd3, 3'd4);
      9'h025: res = hit_pos(3'd4, 3'd4);
      9'h02E: res = hit_pos(3'd5, 3'd4);
      9'h036: res = hit_pos(3'd6, 3'd4);
      9'h03D: res = hit_pos(3'd7, 3'd4);
      9'h03E: res = hit_pos(3'd0, 3'd5);
      9'h046: res = hit_pos(3'd1, 3'd5);
      9'h052: res = hit_pos(3'd2, 3'd5);
      9'h04C: res = hit_pos(3'd3, 3'd5);
      9'h041: res = hit_pos(3'd4, 3'd5);
      9'h04E: res = hit_pos(3'd5, 3'd5);
      9'h049: res = hit_pos(3'd6, 3'd5);
      9'h04A: res = hit_pos(3'd7, 3'd5);
      9'h014: res = hit_pos(3'd0, 3'd6);
      9'h114: res = hit_pos(3'd0, 3'd6);
      9'h076: res = hit_pos(3'd2, 3'd6);
      9'h012: res = {1'b1, POS_SHIFT};
      9'h059: res = {1'b1, POS_SHIFT};
      default: res = 7'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ps2_keymatrix_if.sv
// Byte stream from the PS/2 host receiver into the keyboard matrix block.
interface ps2_keymatrix_if;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output rx_data, output rx_ready);
  modport slave  (input  rx_data, input  rx_ready);
endinterface

// File: rtl/ps2_kbd_decoder.sv
// Prefix-tracking scancode decoder: turns E0/F0/E1 sequences into one-cycle
// make/break events plus an image-clear pulse for BAT and overrun bytes.
module ps2_kbd_decoder
  import mc10_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       evt,
  output logic       make,
  output logic       ext,
  output logic [7:0] code,
  output logic       clr
);

  kbd_state_t state_r, state_s;
  logic [2:0] skip_r, skip_s;

  // State and Pause skip counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      skip_r  <= 3'd0;
    end else begin
      state_r <= state_s;
      skip_r  <= skip_s;
    end
  end

  // Next-state and event decode; events are Mealy so the matrix updates on the strobe edge
  always_comb begin
    state_s = state_r;
    skip_s  = skip_r;
    evt     = 1'b0;
    make    = 1'b0;
    ext     = 1'b0;
    code    = rx_data;
    clr     = 1'b0;
    if (rx_ready) begin
      case (state_r)
        ST_IDLE, ST_EXT: begin
          if (rx_data == SC_E0) begin
            state_s = ST_EXT;
          end else if (rx_data == SC_E1) begin
            state_s = ST_SKIP;
            skip_s  = PAUSE_SKIP;
          end else if (rx_data == SC_F0) begin
            state_s = (state_r == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          end else if (state_r == ST_EXT) begin
            evt     = 1'b1;
            make    = 1'b1;
            ext     = 1'b1;
            state_s = ST_IDLE;
          end else if (rx_data == SC_AA || rx_data == SC_00 || rx_data == SC_FF) begin
            clr = 1'b1;
          end else if (rx_data == SC_FA || rx_data == SC_FE) begin
            state_s = ST_IDLE;
          end else begin
            evt  = 1'b1;
            make = 1'b1;
          end
        end
        ST_BRK: begin
          evt     = 1'b1;
          state_s = ST_IDLE;
        end
        ST_EXT_BRK: begin
          evt     = 1'b1;
          ext     = 1'b1;
          state_s = ST_IDLE;
        end
        ST_SKIP: begin
          skip_s = skip_r - 3'd1;
          if (skip_r <= 3'd1) begin
            skip_s  = 3'd0;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_SKIP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          skip_s  = 3'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 scancode stream to live MC-10 keyboard matrix with active-low row
// returns, F12 machine-reset request and shift status.
module ps2_keymatrix
  import mc10_kbd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  ps2_keymatrix_if.slave        rx,
  input  logic [7:0]            col_sel,
  output logic [6:0]            row_q,
  output logic                  reset_req,
  output logic                  shift_q
);

  logic       evt_s, make_s, ext_s, clr_s;
  logic [7:0] code_s;
  logic [6:0] lk_s;
  logic [2:0] lk_col_s, lk_row_s;
  logic       lk_hit_s;

  logic [7:0][6:0] key_r, key_s;
  logic            shl_r, shl_s, shr_r, shr_s;
  logic            reset_req_r, reset_req_s;
  logic            shift_q_r;
  logic [6:0]      row_hit_s;

  ps2_kbd_decoder u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx.rx_data),
    .rx_ready (rx.rx_ready),
    .evt      (evt_s),
    .make     (make_s),
    .ext      (ext_s),
    .code     (code_s),
    .clr      (clr_s)
  );

  assign lk_s     = lookup(ext_s, code_s);
  assign lk_hit_s = lk_s[6] && (lk_s[2:0] != 3'd7);
  assign lk_col_s = lk_s[5:3];
  assign lk_row_s = lk_s[2:0];

  // Next image and flags; the shift bit follows the OR of both shift flags
  always_comb begin
    key_s       = key_r;
    shl_s       = shl_r;
    shr_s       = shr_r;
    reset_req_s = reset_req_r;
    if (clr_s) begin
      key_s       = '0;
      shl_s       = 1'b0;
      shr_s       = 1'b0;
      reset_req_s = 1'b0;
    end else if (evt_s) begin
      if (!ext_s && code_s == SC_F12) begin
        reset_req_s = make_s;
      end else begin
        reset_req_s = reset_req_r;
      end
      if (!ext_s && code_s == SC_LSHIFT) begin
        shl_s = make_s;
      end else if (!ext_s && code_s == SC_RSHIFT) begin
        shr_s = make_s;
      end else begin
        shl_s = shl_r;
      end
      if (lk_hit_s && {lk_col_s, lk_row_s} != POS_SHIFT) begin
        key_s[lk_col_s][lk_row_s] = make_s;
      end else begin
        key_s = key_r;
      end
      key_s[POS_SHIFT[5:3]][POS_SHIFT[2:0]] = shl_s | shr_s;
    end else begin
      key_s = key_r;
    end
  end

  // Matrix image, flags and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_r       <= '0;
      shl_r       <= 1'b0;
      shr_r       <= 1'b0;
      reset_req_r <= 1'b0;
      shift_q_r   <= 1'b0;
    end else begin
      key_r       <= key_s;
      shl_r       <= shl_s;
      shr_r       <= shr_s;
      reset_req_r <= reset_req_s;
      shift_q_r   <= shl_s | shr_s;
    end
  end

  // Row mux: a row is pulled low by any pressed key in a strobed column
  always_comb begin
    row_hit_s = 7'h00;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 8; c++) begin
        row_hit_s[r] = row_hit_s[r] | (key_r[c][r] & ~col_sel[c]);
      end
    end
  end

  assign row_q     = ~row_hit_s;
  assign reset_req = reset_req_r;
  assign shift_q   = shift_q_r;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Directed bench for ps2_keymatrix: make/break, extended, Pause, shift,
// F12 reset request, synchronous reset and overrun clear.
module tb_ps2_keymatrix;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] col_sel;
  logic [6:0] row_q;
  logic       reset_req;
  logic       shift_q;
  int         checks = 0;
  int         errors = 0;

  ps2_keymatrix_if bus ();

  ps2_keymatrix dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (bus),
    .col_sel   (col_sel),
    .row_q     (row_q),
    .reset_req (reset_req),
    .shift_q   (shift_q)
  );

  always #5 clk = ~clk;

  // One byte per call; consecutive calls strobe rx_ready on consecutive edges
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [7:0] cs, input logic [6:0] exp);
    col_sel = cs;
    #1;
    chk(tag, {1'b0, row_q}, {1'b0, exp});
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    col_sel      = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk_row("reset_row_all", 8'h00, 7'h7F);
    chk_row("reset_row_none", 8'hFF, 7'h7F);
    chk("reset_req_rst", {7'd0, reset_req}, 8'h00);
    chk("shift_q_rst", {7'd0, shift_q}, 8'h00);

    // make / break A
    send(8'h1C);
    chk_row("make_a", 8'hFD, 7'h7E);
    chk_row("make_a_other_col", 8'hFE, 7'h7F);
    send(8'hF0);
    send(8'h1C);
    chk_row("break_a", 8'hFD, 7'h7F);

    // A and ENTER held together
    send(8'h1C);
    send(8'h5A);
    chk_row("multi_col", 8'hBD, 7'h76);
    chk_row("multi_none", 8'hFF, 7'h7F);
    chk_row("multi_enter_only", 8'hBF, 7'h77);
    send(8'hF0);
    send(8'h1C);
    send(8'hF0);
    send(8'h5A);
    chk_row("multi_release", 8'h00, 7'h7F);

    // fake shifts ignored, FSM back to IDLE
    send(8'hE0);
    send(8'h12);
    send(8'hE0);
    send(8'hF0);
    send(8'h12);
    chk_row("fake_shift_row", 8'h00, 7'h7F);
    chk("fake_shift_flag", {7'd0, shift_q}, 8'h00);
    send(8'h1C);
    chk_row("after_ext_make", 8'hFD, 7'h7E);

    // Pause sequence with A held, then a normal byte
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk_row("pause_unchanged", 8'h00, 7'h7E);
    send(8'h5A);
    chk_row("after_pause", 8'hBF, 7'h77);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h5A);
    chk_row("pause_release", 8'h00, 7'h7F);

    // two shift keys tracked separately
    send(8'h12);
    send(8'h59);
    chk("shift_both", {7'd0, shift_q}, 8'h01);
    chk_row("shift_row", 8'h7F, 7'h3F);
    send(8'hF0);
    send(8'h12);
    chk("shift_one_left", {7'd0, shift_q}, 8'h01);
    chk_row("shift_row_one", 8'h7F, 7'h3F);
    send(8'hF0);
    send(8'h59);
    chk("shift_none", {7'd0, shift_q}, 8'h00);
    chk_row("shift_row_none", 8'h7F, 7'h7F);

    // F12 reset request, never in the matrix
    send(8'h07);
    chk("f12_make", {7'd0, reset_req}, 8'h01);
    chk_row("f12_matrix", 8'h00, 7'h7F);
    send(8'hF0);
    send(8'h07);
    chk("f12_break", {7'd0, reset_req}, 8'h00);

    // reset dominates a simultaneous F0 strobe
    send(8'h1C);
    chk_row("pre_reset_a", 8'hFD, 7'h7E);
    rst_n        = 1'b0;
    bus.rx_data  = 8'hF0;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    chk_row("reset_clears", 8'h00, 7'h7F);
    send(8'h1C);
    chk_row("post_reset_make", 8'hFD, 7'h7E);

    // overrun clears everything
    send(8'h5A);
    send(8'h12);
    send(8'h07);
    chk("pre_ovr_shift", {7'd0, shift_q}, 8'h01);
    send(8'hFF);
    chk_row("ovr_clear", 8'h00, 7'h7F);
    chk("ovr_shift", {7'd0, shift_q}, 8'h00);
    chk("ovr_reset_req", {7'd0, reset_req}, 8'h00);

    // BAT clear
    send(8'h1C);
    send(8'hAA);
    chk_row("bat_clear", 8'h00, 7'h7F);
    send(8'h29);
    chk_row("space_make", 8'h7F, 7'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
